// File: rtl/multi_mode_clock.sv
// Hour/minute/second clock with field-by-field setting, external time load and
// 12/24-hour BCD display output for the 7-segment decoders.
module multi_mode_clock #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SET_SECONDS   = 1,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulsed_set,
  input  logic       pulsed_up,
  input  logic       pulsed_down,
  input  logic       mode_12h,
  input  logic       ext_load,
  input  logic [4:0] ext_hours,
  input  logic [5:0] ext_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] current_state,
  output logic [2:0] field_sel,
  output logic       is_pm,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SEC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] prescaler;
  logic [4:0]       live_h, shadow_h;
  logic [5:0]       live_m, live_s, shadow_m, shadow_s;
  logic             sec_tick, commit, enter_set, ext_ok, edit;
  logic [4:0]       disp_h, hour_shown;
  logic [5:0]       disp_m, disp_s;

  // One step up or down with wrap between 0 and max_v.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    field_sel = 3'b000;
    case (state)
      RUN: begin
        if (pulsed_set) state_nxt = SET_H;
      end
      SET_H: begin
        field_sel = 3'b100;
        if (pulsed_set) state_nxt = SET_M;
      end
      SET_M: begin
        field_sel = 3'b010;
        if (pulsed_set) begin
          if (SET_SECONDS != 0) begin
            state_nxt = SET_S;
          end else begin
            state_nxt = RUN;
            commit    = 1'b1;
          end
        end
      end
      SET_S: begin
        field_sel = 3'b001;
        if (pulsed_set) begin
          state_nxt = RUN;
          commit    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign sec_tick  = (prescaler == LAST_TICK);
  assign enter_set = (state == RUN) && pulsed_set;
  assign ext_ok    = (state == RUN) && ext_load && !pulsed_set &&
                     (ext_hours <= 5'd23) && (ext_minutes <= 6'd59);
  assign edit      = (state != RUN) && !pulsed_set && (pulsed_up != pulsed_down);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Commit and external load both restart the second from its beginning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      live_h    <= 5'd0;
      live_m    <= 6'd0;
      live_s    <= 6'd0;
    end else if (commit) begin
      prescaler <= '0;
      live_h    <= shadow_h;
      live_m    <= shadow_m;
      live_s    <= (SET_SECONDS != 0) ? shadow_s : 6'd0;
    end else if (ext_ok) begin
      prescaler <= '0;
      live_h    <= ext_hours;
      live_m    <= ext_minutes;
      live_s    <= 6'd0;
    end else begin
      prescaler <= sec_tick ? '0 : prescaler + CNT_W'(1);
      if (sec_tick) begin
        live_s <= step_wrap(live_s, 6'd59, 1'b1);
        if (live_s == 6'd59) begin
          live_m <= step_wrap(live_m, 6'd59, 1'b1);
          if (live_m == 6'd59) live_h <= 5'(step_wrap({1'b0, live_h}, 6'd23, 1'b1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_h <= 5'd0;
      shadow_m <= 6'd0;
      shadow_s <= 6'd0;
    end else if (enter_set) begin
      shadow_h <= live_h;
      shadow_m <= live_m;
      shadow_s <= live_s;
    end else if (edit) begin
      case (state)
        SET_H:   shadow_h <= 5'(step_wrap({1'b0, shadow_h}, 6'd23, pulsed_up));
        SET_M:   shadow_m <= step_wrap(shadow_m, 6'd59, pulsed_up);
        SET_S:   shadow_s <= step_wrap(shadow_s, 6'd59, pulsed_up);
        default: ;
      endcase
    end
  end

  // Display follows the shadow copy while a field is being edited.
  always_comb begin
    disp_h = (state == RUN) ? live_h : shadow_h;
    disp_m = (state == RUN) ? live_m : shadow_m;
    disp_s = (state == RUN) ? live_s : shadow_s;
    hour_shown = disp_h;
    if (mode_12h) begin
      if (disp_h == 5'd0)      hour_shown = 5'd12;
      else if (disp_h > 5'd12) hour_shown = disp_h - 5'd12;
    end
  end

  assign is_pm         = (disp_h >= 5'd12);
  assign digit5        = 4'(hour_shown / 5'd10);
  assign digit4        = 4'(hour_shown % 5'd10);
  assign digit3        = 4'(disp_m / 6'd10);
  assign digit2        = 4'(disp_m % 6'd10);
  assign digit1        = 4'(disp_s / 6'd10);
  assign digit0        = 4'(disp_s % 6'd10);
  assign hours         = live_h;
  assign minutes       = live_m;
  assign seconds       = live_s;
  assign current_state = state;

endmodule

// File: tb/tb_multi_mode_clock.sv
// Bench for multi_mode_clock: two instances (with and without a seconds field)
// driven in parallel and compared every cycle against a seconds-of-day model.
module tb_multi_mode_clock;

  localparam int TICKS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulsed_set, pulsed_up, pulsed_down, mode_12h, ext_load;
  logic [4:0] ext_hours;
  logic [5:0] ext_minutes;

  logic [4:0] obs_hours   [2];
  logic [5:0] obs_minutes [2];
  logic [5:0] obs_seconds [2];
  logic [1:0] obs_state   [2];
  logic [2:0] obs_fsel    [2];
  logic       obs_pm      [2];
  logic [3:0] obs_d       [2][6];

  int t_live [2];
  int t_pre  [2];
  int t_st   [2];
  int t_sh_h [2];
  int t_sh_m [2];
  int t_sh_s [2];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_mode_clock #(.TICKS_PER_SEC(TICKS), .SET_SECONDS(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .pulsed_set(pulsed_set), .pulsed_up(pulsed_up),
    .pulsed_down(pulsed_down), .mode_12h(mode_12h), .ext_load(ext_load),
    .ext_hours(ext_hours), .ext_minutes(ext_minutes), .hours(obs_hours[0]),
    .minutes(obs_minutes[0]), .seconds(obs_seconds[0]), .current_state(obs_state[0]),
    .field_sel(obs_fsel[0]), .is_pm(obs_pm[0]), .digit0(obs_d[0][0]), .digit1(obs_d[0][1]),
    .digit2(obs_d[0][2]), .digit3(obs_d[0][3]), .digit4(obs_d[0][4]), .digit5(obs_d[0][5])
  );

  multi_mode_clock #(.TICKS_PER_SEC(TICKS), .SET_SECONDS(0), .CNT_W(2)) dut_nosec (
    .clk(clk), .reset(reset), .pulsed_set(pulsed_set), .pulsed_up(pulsed_up),
    .pulsed_down(pulsed_down), .mode_12h(mode_12h), .ext_load(ext_load),
    .ext_hours(ext_hours), .ext_minutes(ext_minutes), .hours(obs_hours[1]),
    .minutes(obs_minutes[1]), .seconds(obs_seconds[1]), .current_state(obs_state[1]),
    .field_sel(obs_fsel[1]), .is_pm(obs_pm[1]), .digit0(obs_d[1][0]), .digit1(obs_d[1][1]),
    .digit2(obs_d[1][2]), .digit3(obs_d[1][3]), .digit4(obs_d[1][4]), .digit5(obs_d[1][5])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [23:0] digitsOf(input int i);
    return {obs_d[i][5], obs_d[i][4], obs_d[i][3], obs_d[i][2], obs_d[i][1], obs_d[i][0]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      t_live[i] = 0; t_pre[i] = 0; t_st[i] = 0;
      t_sh_h[i] = 0; t_sh_m[i] = 0; t_sh_s[i] = 0;
    end
  endtask

  // Next-state of instance i given the inputs present at the coming edge.
  task automatic modelStep(input int i);
    int  ss, d;
    bit  tick, last;
    ss   = (i == 0) ? 1 : 0;
    tick = (t_pre[i] == TICKS - 1);
    last = (ss == 1) ? (t_st[i] == 3) : (t_st[i] == 2);
    if (pulsed_set && t_st[i] != 0 && last) begin
      t_live[i] = t_sh_h[i] * 3600 + t_sh_m[i] * 60 + ((ss == 1) ? t_sh_s[i] : 0);
      t_pre[i]  = 0;
      t_st[i]   = 0;
      return;
    end
    if (pulsed_set && t_st[i] == 0) begin
      t_sh_h[i] = t_live[i] / 3600;
      t_sh_m[i] = (t_live[i] / 60) % 60;
      t_sh_s[i] = t_live[i] % 60;
      t_st[i]   = 1;
    end else if (pulsed_set) begin
      t_st[i] = t_st[i] + 1;
    end else if (t_st[i] == 0 && ext_load && ext_hours <= 23 && ext_minutes <= 59) begin
      t_live[i] = int'(ext_hours) * 3600 + int'(ext_minutes) * 60;
      t_pre[i]  = 0;
      return;
    end else if (t_st[i] != 0 && pulsed_up != pulsed_down) begin
      d = pulsed_up ? 1 : -1;
      case (t_st[i])
        1:       t_sh_h[i] = (t_sh_h[i] + d + 24) % 24;
        2:       t_sh_m[i] = (t_sh_m[i] + d + 60) % 60;
        default: t_sh_s[i] = (t_sh_s[i] + d + 60) % 60;
      endcase
    end
    if (tick) begin
      t_pre[i]  = 0;
      t_live[i] = (t_live[i] + 1) % 86400;
    end else begin
      t_pre[i] = t_pre[i] + 1;
    end
  endtask

  task automatic checkOutput(input int i);
    int dh, dm, ds, shown, dig, fsel;
    dh = (t_st[i] == 0) ? t_live[i] / 3600 : t_sh_h[i];
    dm = (t_st[i] == 0) ? (t_live[i] / 60) % 60 : t_sh_m[i];
    ds = (t_st[i] == 0) ? t_live[i] % 60 : t_sh_s[i];
    shown = mode_12h ? ((dh % 12 == 0) ? 12 : dh % 12) : dh;
    dig = ((shown / 10) << 20) | ((shown % 10) << 16) | ((dm / 10) << 12) |
          ((dm % 10) << 8) | ((ds / 10) << 4) | (ds % 10);
    fsel = (t_st[i] == 0) ? 0 : (1 << (3 - t_st[i]));
    chk($sformatf("d%0d.hours", i), 32'(obs_hours[i]), t_live[i] / 3600);
    chk($sformatf("d%0d.minutes", i), 32'(obs_minutes[i]), (t_live[i] / 60) % 60);
    chk($sformatf("d%0d.seconds", i), 32'(obs_seconds[i]), t_live[i] % 60);
    chk($sformatf("d%0d.state", i), 32'(obs_state[i]), t_st[i]);
    chk($sformatf("d%0d.field_sel", i), 32'(obs_fsel[i]), fsel);
    chk($sformatf("d%0d.is_pm", i), 32'(obs_pm[i]), (dh >= 12) ? 1 : 0);
    chk($sformatf("d%0d.digits", i), 32'(digitsOf(i)), dig);
  endtask

  // One clock edge with the inputs currently driven, then compare both instances.
  task automatic applyStimulus();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkOutput(0);
    checkOutput(1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic pulse(input logic s, input logic u, input logic d);
    pulsed_set = s; pulsed_up = u; pulsed_down = d;
    applyStimulus();
    pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0;
  endtask

  task automatic extPulse(input logic [4:0] h, input logic [5:0] m);
    ext_load = 1'b1; ext_hours = h; ext_minutes = m;
    applyStimulus();
    ext_load = 1'b0;
  endtask

  task automatic pulseReset();
    pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0; ext_load = 1'b0;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput(0);
    checkOutput(1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; pulsed_set = 1'b0; pulsed_up = 1'b0; pulsed_down = 1'b0;
    mode_12h = 1'b0; ext_load = 1'b0; ext_hours = 5'd0; ext_minutes = 6'd0;
    modelReset();
    #3;
    checkOutput(0);
    checkOutput(1);
    @(negedge clk);
    reset = 1'b1;

    idle(4 * 60);
    chk("one_minute_min", 32'(obs_minutes[0]), 1);
    chk("one_minute_digits", 32'(digitsOf(0)), 32'h000100);

    extPulse(5'd0, 6'd0);
    pulse(1, 0, 0); pulse(0, 0, 1);
    pulse(1, 0, 0); pulse(0, 0, 1);
    pulse(1, 0, 0); pulse(0, 0, 1);
    pulse(1, 0, 0);
    chk("commit_235959_h", 32'(obs_hours[0]), 23);
    chk("commit_235959_s", 32'(obs_seconds[0]), 59);
    mode_12h = 1'b1;
    idle(3);
    chk("pre_rollover_s", 32'(obs_seconds[0]), 59);
    idle(1);
    chk("rollover_h", 32'(obs_hours[0]), 0);
    chk("rollover_12h_digits", 32'(digitsOf(0)), 32'h120000);
    chk("rollover_is_pm", 32'(obs_pm[0]), 0);

    pulseReset();
    mode_12h = 1'b0;
    idle(2);
    pulse(1, 0, 0); pulse(0, 0, 1); pulse(1, 0, 0);
    pulsed_up = 1'b1;
    idle(61);
    pulsed_up = 1'b0;
    chk("live_runs_in_set", 32'(obs_seconds[0]), 16);
    pulse(1, 0, 0); pulse(1, 0, 0);
    chk("commit_h", 32'(obs_hours[0]), 23);
    chk("commit_m", 32'(obs_minutes[0]), 1);
    chk("commit_s", 32'(obs_seconds[0]), 0);

    pulseReset();
    idle(10);
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
    chk("nosec_back_to_run", 32'(obs_state[1]), 0);
    chk("nosec_seconds_zero", 32'(obs_seconds[1]), 0);
    chk("sec_in_set_s", 32'(obs_state[0]), 3);

    pulseReset();
    mode_12h = 1'b1;
    extPulse(5'd13, 6'd45);
    chk("ext_h", 32'(obs_hours[0]), 13);
    chk("ext_m", 32'(obs_minutes[0]), 45);
    chk("ext_12h_digits", 32'(digitsOf(0)), 32'h014500);
    chk("ext_is_pm", 32'(obs_pm[0]), 1);
    extPulse(5'd24, 6'd10);
    chk("ext_bad_hour_h", 32'(obs_hours[0]), 13);
    extPulse(5'd3, 6'd60);
    chk("ext_bad_min_m", 32'(obs_minutes[0]), 45);
    pulse(1, 0, 0); pulse(1, 0, 0);
    extPulse(5'd5, 6'd5);
    chk("ext_in_set_state", 32'(obs_state[0]), 2);
    chk("ext_in_set_h", 32'(obs_hours[0]), 13);

    pulseReset();
    mode_12h = 1'b0;
    pulse(1, 0, 0);
    pulse(0, 1, 1);
    chk("updown_state", 32'(obs_state[0]), 1);
    chk("updown_digits", 32'(digitsOf(0)), 32'h000000);
    pulse(1, 1, 0);
    chk("set_wins_state", 32'(obs_state[0]), 2);
    chk("set_wins_digits", 32'(digitsOf(0)), 32'h000000);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulseReset();
    chk("reset_in_set_state", 32'(obs_state[0]), 0);
    chk("reset_in_set_s", 32'(obs_seconds[0]), 0);

    for (int n = 0; n < 1500; n++) begin
      pulsed_set  = ($urandom_range(0, 7) == 0);
      pulsed_up   = ($urandom_range(0, 3) == 0);
      pulsed_down = ($urandom_range(0, 3) == 0);
      ext_load    = ($urandom_range(0, 15) == 0);
      ext_hours   = 5'($urandom_range(0, 31));
      ext_minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
      applyStimulus();
      if ($urandom_range(0, 299) == 0) pulseReset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
